ps2_key_sequencer: RTL and testbench
====================================

Name: ps2_key_sequencer

Overview:
- Sequences the PS/2 keyboard receive path for the snake game, in the system clock domain.
- Samples the keyboard clock and data lines and frames 11-bit PS/2 words with start, parity and stop checks.
- Resolves E0 (extended) and F0 (break) prefixes into single key events, delivered over a valid/ack handshake.
- Keeps a latched snake direction from arrow-key make codes; sits between the PS/2 pins and the game FSM.

Parameters:
- FILTER_LEN, 4: consecutive equal synchronised samples required before filtered ps2_clk changes.
- TIMEOUT_CYCLES, 50000: clk cycles without a bit strobe mid-frame before the frame is abandoned (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- kclk  in  1  raw PS/2 clock from keyboard (asynchronous).
- data  in  1  raw PS/2 data from keyboard (asynchronous).
- key_code  out  8  scan code of the pending event.
- key_break  out  1  pending event is a release (F0-prefixed).
- key_ext  out  1  pending event is extended (E0-prefixed).
- key_valid  out  1  event pending; held until acknowledged.
- key_ack  in  1  consumer accepts the event this cycle.
- dir  out  2  latched direction: 0 up, 1 down, 2 left, 3 right.
- dir_change  out  1  one-cycle pulse when dir is written.
- frame_err  out  1  one-cycle pulse on start, parity or stop error, or on timeout.
- overrun  out  1  one-cycle pulse when an event is dropped.

Behaviour:
- Reset values: all outputs 0; dir=0 (up); FSM in IDLE; prefix flags cleared; filter state 1 (bus idle high).
- Synchronisation: 2-FF synchronisers on kclk and data.
- Filtering: filtered clock toggles only after FILTER_LEN consecutive equal samples.
- Bit strobe: filtered clock 1->0; data sampled in the same cycle.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: strobe with data=0 -> DATA with bit count 0. Strobe with data=1 is ignored.
  - DATA: 8 strobes, LSB first -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: the strobe ends the frame -> IDLE. The frame is valid only if stop=1 and data+parity has odd weight; otherwise frame_err pulses and the byte is discarded.
- Timeout: counter resets on each strobe and counts only outside IDLE. Reaching TIMEOUT_CYCLES -> IDLE with a frame_err pulse.
- Byte sequencing (on each valid byte):
  - E0 sets ext_pend.
  - F0 sets brk_pend.
  - Any other byte emits an event {byte, brk_pend, ext_pend} and clears both flags.
  - frame_err also clears both flags.
- Event latency: key_valid asserts on the clk edge after the cycle that holds the stop strobe.
- Output register (one entry):
  - key_valid && key_ack: entry cleared next cycle.
  - New event while key_valid=1 and key_ack=0: new event dropped, overrun pulses, old entry held unchanged.
  - New event in the same cycle as key_ack: new event loaded, key_valid stays 1, no overrun.
- Direction:
  - On emit of an extended make event: 75 -> up, 72 -> down, 6B -> left, 74 -> right.
  - dir updates and dir_change pulses in the same cycle key_valid rises. This is independent of overrun: dir still updates if the event is dropped.
  - Break codes and non-arrow codes never change dir.
  - Reversal filtering is the game FSM's job, not this block's.
- Reset mid-frame: everything returns to reset values on the next clk edge. Remaining keyboard bits are discarded until a start bit arrives in IDLE.

Decomposition:
- Package ps2_pkg holds:
  - PS2_EXT = 8'hE0, PS2_BRK = 8'hF0.
  - Arrow codes 75/72/6B/74.
  - Direction encodings DIR_UP/DOWN/LEFT/RIGHT.
  - Frame FSM state constants.
- Sub-module ps2_rx_frame: synchronisers, filter, frame FSM and timeout; outputs byte_valid, byte_data[7:0], byte_err.
- The top level holds the prefix flags, the event register, the handshake and the direction logic.

Test Plan:
- Single frame 0x1C (parity 0, stop 1), key_ack tied 1 -> one event: key_code=1C, key_break=0, key_ext=0; valid lasts 1 cycle; no frame_err.
- Frames E0, 6B -> event {6B, brk 0, ext 1}; dir=2 and dir_change pulses once. Then E0, F0, 6B -> event {6B, brk 1, ext 1}; dir unchanged.
- Frame 0x72 sent with parity 0 (wrong) -> frame_err pulse, no event, dir unchanged. A following correct E0, 72 -> dir=1.
- Ten data bits of a frame, then kclk held high for TIMEOUT_CYCLES+10 cycles -> frame_err pulse; the next clean 0x1C frame is received correctly.
- key_ack held 0, send 1C then 32 -> key_code stays 1C, overrun pulses once. Assert ack in the same cycle as a third event 21 -> key_code=21, key_valid stays 1, no overrun.
- Assert reset after 5 data bits of E0 -> outputs return to reset values; the next clean 75 frame yields {75, ext 0} with dir unchanged.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 receive path: prefix bytes, arrow scan codes,
// direction encodings, frame FSM states and small decode helpers.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_t;

    // PS/2 uses odd parity over the eight data bits plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
        return ^{b, p};
    endfunction

    // Returns {is_arrow, direction}.
    function automatic logic [2:0] arrow_decode(input logic [7:0] code);
        logic [2:0] r;
        case (code)
            KEY_UP:    r = {1'b1, DIR_UP};
            KEY_DOWN:  r = {1'b1, DIR_DOWN};
            KEY_LEFT:  r = {1'b1, DIR_LEFT};
            KEY_RIGHT: r = {1'b1, DIR_RIGHT};
            default:   r = 3'b000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 line receiver: synchronises and deglitches the keyboard lines, frames
// 11-bit words and reports each byte as valid or erroneous for one cycle.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       kclk,
    input  logic       data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          kclk_meta_q, kclk_sync_q, data_meta_q, data_sync_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    frame_state_t  state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          strobe_s, timeout_s, frame_end_s, frame_ok_s;

    // Synchronisers, filter, frame state and timeout registers; lines idle high.
    always_ff @(posedge clk) begin
        if (reset) begin
            kclk_meta_q <= 1'b1;
            kclk_sync_q <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            filt_q      <= 1'b1;
            filt_cnt_q  <= '0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            par_q       <= 1'b0;
            tmo_q       <= '0;
        end else begin
            kclk_meta_q <= kclk;
            kclk_sync_q <= kclk_meta_q;
            data_meta_q <= data;
            data_sync_q <= data_meta_q;
            filt_q      <= filt_d;
            filt_cnt_q  <= filt_cnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
        end
    end

    // Clock filter: the filtered level flips after FILTER_LEN differing samples.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (kclk_sync_q != filt_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d     = kclk_sync_q;
                filt_cnt_d = '0;
            end else begin
                filt_cnt_d = filt_cnt_q + FW'(1);
            end
        end else begin
            filt_cnt_d = '0;
        end
    end

    assign strobe_s  = filt_q & ~filt_d;
    assign timeout_s = (state_q != ST_IDLE) && !strobe_s &&
                       (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    // Frame FSM next state plus shift register, bit counter and timeout counter.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        case (state_q)
            ST_IDLE: begin
                if (strobe_s && !data_sync_q) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = 3'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (strobe_s) begin
                    shift_d   = {data_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (strobe_s) begin
                    par_d   = data_sync_q;
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (strobe_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (timeout_s) begin
            state_d = ST_IDLE;
        end else begin
            state_d = state_d;
        end
        if ((state_q == ST_IDLE) || strobe_s) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    // Frame result outputs, valid in the cycle holding the stop strobe.
    always_comb begin
        frame_end_s = (state_q == ST_STOP) && strobe_s;
        frame_ok_s  = data_sync_q && odd_parity_ok(shift_q, par_q);
        byte_valid  = frame_end_s && frame_ok_s;
        byte_err    = (frame_end_s && !frame_ok_s) || timeout_s;
        byte_data   = shift_q;
    end

endmodule

// File: rtl/ps2_key_sequencer.sv
// PS/2 key sequencer: folds E0/F0 prefixes into key events, holds one event
// for a valid/ack consumer and latches the snake direction from arrow makes.
module ps2_key_sequencer
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       kclk,
    input  logic       data,
    output logic [7:0] key_code,
    output logic       key_break,
    output logic       key_ext,
    output logic       key_valid,
    input  logic       key_ack,
    output logic [1:0] dir,
    output logic       dir_change,
    output logic       frame_err,
    output logic       overrun
);

    logic       byte_valid_s, byte_err_s, emit_s;
    logic [7:0] byte_data_s;
    logic [2:0] arrow_s;
    logic       ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
    logic [7:0] code_q, code_d;
    logic       brk_q, brk_d, ext_q, ext_d, valid_q, valid_d;
    logic [1:0] dir_q, dir_d;
    logic       dir_change_q, dir_change_d, frame_err_q, frame_err_d;
    logic       overrun_q, overrun_d;

    ps2_rx_frame #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .kclk      (kclk),
        .data      (data),
        .byte_valid(byte_valid_s),
        .byte_data (byte_data_s),
        .byte_err  (byte_err_s)
    );

    // Prefix flags, event entry, direction and status pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ext_pend_q   <= 1'b0;
            brk_pend_q   <= 1'b0;
            code_q       <= 8'h00;
            brk_q        <= 1'b0;
            ext_q        <= 1'b0;
            valid_q      <= 1'b0;
            dir_q        <= DIR_UP;
            dir_change_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            ext_pend_q   <= ext_pend_d;
            brk_pend_q   <= brk_pend_d;
            code_q       <= code_d;
            brk_q        <= brk_d;
            ext_q        <= ext_d;
            valid_q      <= valid_d;
            dir_q        <= dir_d;
            dir_change_q <= dir_change_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign emit_s  = byte_valid_s && (byte_data_s != PS2_EXT) && (byte_data_s != PS2_BRK);
    assign arrow_s = arrow_decode(byte_data_s);

    // Prefix tracking, single-entry handshake and direction update.
    always_comb begin
        ext_pend_d   = ext_pend_q;
        brk_pend_d   = brk_pend_q;
        code_d       = code_q;
        brk_d        = brk_q;
        ext_d        = ext_q;
        valid_d      = valid_q;
        dir_d        = dir_q;
        dir_change_d = 1'b0;
        overrun_d    = 1'b0;
        frame_err_d  = byte_err_s;

        if (byte_err_s) begin
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end else if (byte_valid_s) begin
            if (byte_data_s == PS2_EXT) begin
                ext_pend_d = 1'b1;
            end else if (byte_data_s == PS2_BRK) begin
                brk_pend_d = 1'b1;
            end else begin
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
            end
        end else begin
            ext_pend_d = ext_pend_q;
        end

        // An ack in the same cycle frees the entry for the incoming event.
        if (emit_s) begin
            if (!valid_q || key_ack) begin
                code_d  = byte_data_s;
                brk_d   = brk_pend_q;
                ext_d   = ext_pend_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && key_ack) begin
            code_d  = 8'h00;
            brk_d   = 1'b0;
            ext_d   = 1'b0;
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        // Direction follows every extended arrow make, even a dropped one.
        if (emit_s && ext_pend_q && !brk_pend_q && arrow_s[2]) begin
            dir_d        = arrow_s[1:0];
            dir_change_d = 1'b1;
        end else begin
            dir_d = dir_q;
        end
    end

    assign key_code   = code_q;
    assign key_break  = brk_q;
    assign key_ext    = ext_q;
    assign key_valid  = valid_q;
    assign dir        = dir_q;
    assign dir_change = dir_change_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Bench for ps2_key_sequencer: bit-banged PS/2 frames, a directed vector
// table, randomized frames against a byte-level model, and handshake corners.
module tb_ps2_key_sequencer;

    localparam int H   = 25;
    localparam int TMO = 2000;

    logic       clk = 1'b0;
    logic       reset, kclk, data, key_ack;
    logic [7:0] key_code;
    logic       key_break, key_ext, key_valid, dir_change, frame_err, overrun;
    logic [1:0] dir;

    ps2_key_sequencer #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .kclk      (kclk),
        .data      (data),
        .key_code  (key_code),
        .key_break (key_break),
        .key_ext   (key_ext),
        .key_valid (key_valid),
        .key_ack   (key_ack),
        .dir       (dir),
        .dir_change(dir_change),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int err_cnt = 0, ovr_cnt = 0, dc_cnt = 0, vc_cnt = 0;
    int snap_ev, snap_err, snap_ovr, snap_dc, snap_vc;
    logic [9:0] ev_q[$];

    // Counts pulses and records each acknowledged event, sampled just after the edge.
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            if (key_valid && key_ack) ev_q.push_back({key_code, key_break, key_ext});
            if (frame_err)  err_cnt++;
            if (overrun)    ovr_cnt++;
            if (dir_change) dc_cnt++;
            if (key_valid)  vc_cnt++;
        end
    end

    typedef struct {
        logic [7:0] b;
        bit         good;
        bit         ev;
        logic [7:0] code;
        bit         brk;
        bit         ext;
        bit         err;
        logic [1:0] d;
        bit         dchg;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            data = bits[i];
            wait_cycles(H);
            kclk = 1'b0;
            wait_cycles(H);
            kclk = 1'b1;
        end
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit good);
        logic p;
        p = good ? ~(^b) : (^b);
        return {1'b1, p, b, 1'b0};
    endfunction

    task automatic send_frame(input logic [7:0] b, input bit good);
        send_bits(frame_bits(b, good), 11);
        data = 1'b1;
        wait_cycles(40);
    endtask

    task automatic take_snap();
        snap_ev  = ev_q.size();
        snap_err = err_cnt;
        snap_ovr = ovr_cnt;
        snap_dc  = dc_cnt;
        snap_vc  = vc_cnt;
    endtask

    task automatic check_frame(input string tag, input bit ev, input logic [7:0] code,
                               input bit brk, input bit ext, input bit err,
                               input logic [1:0] d, input bit dchg);
        check({tag, "_events"}, ev_q.size() - snap_ev, int'(ev));
        if (ev && ev_q.size() > snap_ev)
            check({tag, "_event"}, int'(ev_q[snap_ev]), int'({code, brk, ext}));
        check({tag, "_valid_cycles"}, vc_cnt - snap_vc, int'(ev));
        check({tag, "_frame_err"}, err_cnt - snap_err, int'(err));
        check({tag, "_dir"}, int'(dir), int'(d));
        check({tag, "_dir_change"}, dc_cnt - snap_dc, int'(dchg));
        check({tag, "_overrun"}, ovr_cnt - snap_ovr, 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        wait_cycles(2);
        reset = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_outputs"},
              int'({key_code, key_break, key_ext, key_valid, dir_change, frame_err, overrun}), 0);
        check({tag, "_dir"}, int'(dir), 0);
    endtask

    // Byte-level reference: prefixes accumulate, other bytes emit and clear.
    bit m_ext, m_brk;
    logic [1:0] m_dir;

    task automatic model_byte(input logic [7:0] b, input bit good, output vec_t v);
        v.b = b; v.good = good; v.ev = 1'b0; v.code = 8'h00;
        v.brk = 1'b0; v.ext = 1'b0; v.err = 1'b0; v.dchg = 1'b0;
        if (!good) begin
            v.err = 1'b1; m_ext = 1'b0; m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            v.ev = 1'b1; v.code = b; v.brk = m_brk; v.ext = m_ext;
            if (m_ext && !m_brk) begin
                case (b)
                    8'h75: begin m_dir = 2'd0; v.dchg = 1'b1; end
                    8'h72: begin m_dir = 2'd1; v.dchg = 1'b1; end
                    8'h6B: begin m_dir = 2'd2; v.dchg = 1'b1; end
                    8'h74: begin m_dir = 2'd3; v.dchg = 1'b1; end
                    default: ;
                endcase
            end
            m_ext = 1'b0; m_brk = 1'b0;
        end
        v.d = m_dir;
    endtask

    vec_t vecs[15];
    vec_t mv;
    logic [7:0] pool[6];
    bit got;

    initial begin
        reset = 1'b1; kclk = 1'b1; data = 1'b1; key_ack = 1'b1;
        wait_cycles(4);
        check_reset_state("reset_initial");
        reset = 1'b0;
        wait_cycles(10);

        //          byte   good  ev  code   brk   ext   err   dir   dchg
        vecs[0]  = '{8'h1C, 1'b1, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
        vecs[1]  = '{8'hE0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
        vecs[2]  = '{8'h6B, 1'b1, 1'b1, 8'h6B, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1};
        vecs[3]  = '{8'hE0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0};
        vecs[4]  = '{8'hF0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0};
        vecs[5]  = '{8'h6B, 1'b1, 1'b1, 8'h6B, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0};
        vecs[6]  = '{8'h72, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0};
        vecs[7]  = '{8'hE0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0};
        vecs[8]  = '{8'h72, 1'b1, 1'b1, 8'h72, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1};
        vecs[9]  = '{8'hF0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0};
        vecs[10] = '{8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0};
        vecs[11] = '{8'h74, 1'b1, 1'b1, 8'h74, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0};
        vecs[12] = '{8'hE0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0};
        vecs[13] = '{8'h75, 1'b1, 1'b1, 8'h75, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1};
        vecs[14] = '{8'h21, 1'b1, 1'b1, 8'h21, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};

        for (int i = 0; i < 15; i++) begin
            take_snap();
            send_frame(vecs[i].b, vecs[i].good);
            check_frame($sformatf("vec%0d", i), vecs[i].ev, vecs[i].code, vecs[i].brk,
                        vecs[i].ext, vecs[i].err, vecs[i].d, vecs[i].dchg);
        end

        // Timeout: ten bits, then the clock stays high past the limit.
        take_snap();
        send_bits(frame_bits(8'h1C, 1'b1), 10);
        data = 1'b1;
        wait_cycles(TMO + 10);
        check("timeout_frame_err", err_cnt - snap_err, 1);
        check("timeout_no_event", ev_q.size() - snap_ev, 0);
        take_snap();
        send_frame(8'h1C, 1'b1);
        check_frame("after_timeout", 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);

        // Overrun: consumer stalls, second event dropped, third loaded with ack.
        key_ack = 1'b0;
        take_snap();
        send_frame(8'h1C, 1'b1);
        check("stall_valid", int'(key_valid), 1);
        check("stall_code", int'(key_code), 8'h1C);
        send_frame(8'h32, 1'b1);
        check("overrun_pulses", ovr_cnt - snap_ovr, 1);
        check("overrun_code_held", int'(key_code), 8'h1C);
        check("overrun_valid_held", int'(key_valid), 1);
        take_snap();
        got = 1'b0;
        fork
            send_frame(8'h21, 1'b1);
            begin
                for (int i = 0; i < 1500 && !got; i++) begin
                    @(negedge clk);
                    if (dut.byte_valid_s) begin
                        key_ack = 1'b1;
                        got = 1'b1;
                    end
                end
                @(negedge clk);
                key_ack = 1'b0;
            end
        join
        check("ack_window_found", int'(got), 1);
        check("same_cycle_ack_code", int'(key_code), 8'h21);
        check("same_cycle_ack_valid", int'(key_valid), 1);
        check("same_cycle_ack_no_overrun", ovr_cnt - snap_ovr, 0);
        key_ack = 1'b1;
        wait_cycles(3);
        check("ack_clears_valid", int'(key_valid), 0);

        // Reset mid-frame after a pending E0 and a non-up direction.
        send_frame(8'hE0, 1'b1);
        send_frame(8'h74, 1'b1);
        check("pre_reset_dir", int'(dir), 3);
        send_frame(8'hE0, 1'b1);
        send_bits(frame_bits(8'hE0, 1'b1), 6);
        data = 1'b1;
        pulse_reset();
        #1;
        check_reset_state("reset_midframe");
        wait_cycles(20);
        take_snap();
        send_frame(8'h75, 1'b1);
        check_frame("post_reset", 1'b1, 8'h75, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);

        // Randomized frames against the byte-level model.
        pulse_reset();
        wait_cycles(10);
        m_ext = 1'b0; m_brk = 1'b0; m_dir = 2'd0;
        pool[0] = 8'hE0; pool[1] = 8'hF0; pool[2] = 8'h75;
        pool[3] = 8'h72; pool[4] = 8'h6B; pool[5] = 8'h74;
        for (int i = 0; i < 30; i++) begin
            logic [7:0] b;
            bit good;
            int sel;
            sel  = $urandom_range(0, 7);
            b    = (sel < 6) ? pool[sel] : 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 9) != 0);
            model_byte(b, good, mv);
            take_snap();
            send_frame(b, good);
            check_frame($sformatf("rand%0d_b%02h", i, b), mv.ev, mv.code, mv.brk, mv.ext,
                        mv.err, mv.d, mv.dchg);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
